// File: rtl/ixc_uclk_gen_pkg.sv
// ixc_uclk_gen_pkg
//   Shared types for the multi-channel user-clock generator.
//   DIV_W_DEF : default half-period divide width
//   cfg_t     : one config request {ch, div, en}, sized for the widest legal
//               build (16 channels, 16-bit divide) and narrowed at the use site
//   div_sanitize : maps a zero divide onto 1
package ixc_uclk_gen_pkg;

   localparam int DIV_W_DEF = 8;
   localparam int CH_W_MAX  = 4;
   localparam int DIV_W_MAX = 16;

   typedef struct packed {
      logic [CH_W_MAX-1:0]  ch;
      logic [DIV_W_MAX-1:0] div;
      logic                 en;
   } cfg_t;

   // A half-period of zero would never toggle; treat it as the fastest rate.
   function automatic logic [DIV_W_MAX-1:0] div_sanitize(input logic [DIV_W_MAX-1:0] d);
      return (d == '0) ? DIV_W_MAX'(1) : d;
   endfunction

endpackage

// File: rtl/ixc_uclk_gen_div_ch.sv
// ixc_uclk_div_ch
//   One divided-clock channel: half-period down-counter, output phase, rising
//   edge tick and a one-entry pending config that is applied only at a period
//   boundary so the output never produces a runt.
// Ports
//   uclk     in   base clock, all logic on its rising edge
//   rst      in   synchronous active-high reset
//   sync     in   phase-align request (tied low when the feature is absent)
//   acc      in   config accepted for this channel this cycle
//   acc_div  in   sanitized new half-period
//   acc_en   in   new enable
//   clk_out  out  divided clock (registered phase)
//   tick     out  high on the first high cycle of clk_out
//   pend     out  a config is waiting to be applied
module ixc_uclk_div_ch #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 1,
   parameter bit RESET_EN    = 1'b1
) (
   input  logic             uclk,
   input  logic             rst,
   input  logic             sync,
   input  logic             acc,
   input  logic [DIV_W-1:0] acc_div,
   input  logic             acc_en,
   output logic             clk_out,
   output logic             tick,
   output logic             pend
);

   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] DEF_DIV = (DEFAULT_DIV < 1) ? ONE : DIV_W'(DEFAULT_DIV);

   logic [DIV_W-1:0] div, cnt, p_div;
   logic             en, p_en, phase;

   assign clk_out = phase;

   always_ff @(posedge uclk) begin
      if (rst) begin
         div   <= DEF_DIV;
         cnt   <= DEF_DIV - ONE;
         en    <= RESET_EN;
         phase <= 1'b0;
         tick  <= 1'b0;
         p_div <= DEF_DIV;
         p_en  <= 1'b0;
         pend  <= 1'b0;
      end else begin
         tick <= 1'b0;
         // Accept only happens while pend is clear, so it never races the
         // apply paths below, which all require pend set.
         if (acc) begin
            p_div <= acc_div;
            p_en  <= acc_en;
            pend  <= 1'b1;
         end
         if (en && sync) begin
            // Restart the low phase so every channel rises div cycles later.
            phase <= 1'b0;
            if (pend) begin
               div  <= p_div;
               en   <= p_en;
               cnt  <= p_div - ONE;
               pend <= 1'b0;
            end else begin
               cnt <= div - ONE;
            end
         end else if (en) begin
            if (cnt == '0) begin
               if (!phase && pend) begin
                  // End of a low phase: the safe point to swap ratio/enable.
                  div   <= p_div;
                  en    <= p_en;
                  cnt   <= p_div - ONE;
                  pend  <= 1'b0;
                  phase <= p_en;
                  tick  <= p_en;
               end else begin
                  phase <= !phase;
                  tick  <= !phase;
                  cnt   <= div - ONE;
               end
            end else begin
               cnt <= cnt - ONE;
            end
         end else begin
            // Stopped: hold the count, apply a waiting config immediately and
            // start a full-length low phase from it.
            phase <= 1'b0;
            if (pend) begin
               div  <= p_div;
               en   <= p_en;
               cnt  <= p_div - ONE;
               pend <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/ixc_uclk_gen_multi.sv
// ixc_uclk_gen_multi
//   NUM_CH runtime-programmable divided user clocks derived from uclk, each
//   with a one-cycle rising-edge tick for logic that stays in the uclk domain.
//   Optional macro IXC_UCLK_GEN_SYNC_START_EN adds the sync_start input that
//   phase-aligns every enabled channel.
// Ports
//   uclk        in   base clock
//   rst         in   synchronous active-high reset
//   cfg_valid   in   config request
//   cfg_ready   out  request accepted when valid & ready
//   cfg_ch      in   target channel (out-of-range: accepted and dropped)
//   cfg_div     in   new half-period in uclk cycles, 0 treated as 1
//   cfg_en      in   new enable
//   sync_start  in   (macro only) restart all enabled channels in phase
//   clk_out     out  divided clocks, 50% duty, period 2*div
//   clk_tick    out  pulse on the first high cycle of each clk_out
//   busy        out  any channel has a config pending
// DIV_W may not exceed ixc_uclk_gen_pkg::DIV_W_MAX, NUM_CH may not exceed 16.
module ixc_uclk_gen_multi
   import ixc_uclk_gen_pkg::*;
#(
   parameter int                NUM_CH      = 4,
   parameter int                DIV_W       = DIV_W_DEF,
   parameter int                DEFAULT_DIV = 1,
   parameter logic [NUM_CH-1:0] RESET_EN    = {NUM_CH{1'b1}},
   localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              uclk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_en,
`ifdef IXC_UCLK_GEN_SYNC_START_EN
   input  logic              sync_start,
`endif
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] clk_tick,
   output logic              busy
);

   cfg_t              req;
   logic [DIV_W-1:0]  san_div;
   logic [NUM_CH-1:0] acc, pend;
   logic              sync;

`ifdef IXC_UCLK_GEN_SYNC_START_EN
   assign sync = sync_start;
`else
   assign sync = 1'b0;
`endif

   assign req     = '{ch: CH_W_MAX'(cfg_ch), div: DIV_W_MAX'(cfg_div), en: cfg_en};
   assign san_div = DIV_W'(div_sanitize(req.div));

   // Ready follows the addressed channel's pending flag; an address with no
   // channel behind it matches nothing and is simply swallowed.
   always_comb begin
      cfg_ready = 1'b1;
      acc       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (req.ch == CH_W_MAX'(i)) begin
            cfg_ready = !pend[i];
            acc[i]    = cfg_valid && !pend[i];
         end
      end
   end

   assign busy = |pend;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ixc_uclk_div_ch #(
         .DIV_W      (DIV_W),
         .DEFAULT_DIV(DEFAULT_DIV),
         .RESET_EN   (RESET_EN[g])
      ) u_ch (
         .uclk   (uclk),
         .rst    (rst),
         .sync   (sync),
         .acc    (acc[g]),
         .acc_div(san_div),
         .acc_en (req.en),
         .clk_out(clk_out[g]),
         .tick   (clk_tick[g]),
         .pend   (pend[g])
      );
   end

endmodule

// File: tb/tb_ixc_uclk_gen_multi.sv
// tb_ixc_uclk_gen_multi
//   Directed bench for ixc_uclk_gen_multi (NUM_CH=5 so that an unmapped
//   channel number exists). Expected tick cycles are queued per channel as
//   each configuration is issued; a monitor pops them as ticks appear.
//   Cycle n = state after the n-th rising edge with rst low.
module tb_ixc_uclk_gen_multi;

   localparam int NC    = 5;
   localparam int T_END = 64;

   logic          uclk = 1'b0;
   logic          rst  = 1'b1;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [2:0]    cfg_ch  = '0;
   logic [7:0]    cfg_div = '0;
   logic          cfg_en  = 1'b0;
`ifdef IXC_UCLK_GEN_SYNC_START_EN
   logic          sync_start = 1'b0;
`endif
   logic [NC-1:0] clk_out, clk_tick;
   logic          busy;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   bit mon_on = 1'b0;
   int exp_q[NC][$];

   ixc_uclk_gen_multi #(
      .NUM_CH(NC), .DIV_W(8), .DEFAULT_DIV(1), .RESET_EN(5'b11111)
   ) dut (
      .uclk(uclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
`ifdef IXC_UCLK_GEN_SYNC_START_EN
      .sync_start(sync_start),
`endif
      .clk_out(clk_out), .clk_tick(clk_tick), .busy(busy)
   );

   always #5 uclk = ~uclk;

   always @(posedge uclk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input int first, input int step, input int last);
      for (int t = first; t <= last && t < T_END; t += step) exp_q[c].push_back(t);
   endtask

   // Call only from a falling edge.
   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge uclk);
   endtask

   // Issue one request at this falling edge; it is accepted on the next
   // rising edge. Returns at the following falling edge.
   task automatic drive(input logic [2:0] ch, input logic [7:0] dv, input logic en);
      cfg_valid = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_en = en;
      #1 chk("cfg_ready_on_issue", int'(cfg_ready), 1);
      @(negedge uclk);
      cfg_valid = 1'b0;
   endtask

   // Tick scoreboard: every tick must match the head of its channel queue,
   // and an expected tick whose cycle passes without one is reported.
   always @(negedge uclk) begin : mon
      int t;
      if (mon_on && cyc < T_END) begin
         for (int c = 0; c < NC; c++) begin
            if (clk_tick[c]) begin
               n_chk++;
               if (exp_q[c].size() == 0) begin
                  n_fail++;
                  $display("FAIL tick_ch%0d: got tick at cycle %0d expected none", c, cyc);
               end else begin
                  t = exp_q[c].pop_front();
                  if (t != cyc) begin
                     n_fail++;
                     $display("FAIL tick_ch%0d: got tick at cycle %0d expected cycle %0d", c, cyc, t);
                  end
               end
            end else if (exp_q[c].size() != 0 && exp_q[c][0] <= cyc) begin
               t = exp_q[c].pop_front();
               n_chk++;
               n_fail++;
               $display("FAIL tick_ch%0d: got no tick at cycle %0d expected tick at cycle %0d", c, cyc, t);
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge uclk);
      chk("rst_clk_out",   int'(clk_out), 0);
      chk("rst_clk_tick",  int'(clk_tick), 0);
      chk("rst_busy",      int'(busy), 0);
      chk("rst_cfg_ready", int'(cfg_ready), 1);
      rst = 1'b0;
      mon_on = 1'b1;

      // Defaults: div=1 everywhere, ticks on odd cycles until reconfigured.
      push(0, 1, 2, 5);
      push(3, 1, 2, 5);
      push(4, 1, 2, 7);
      push(2, 1, 2, 9);  push(2, 15, 1, 15);
      push(1, 1, 2, 9);  push(1, 11, 4, 27);

      @(negedge uclk);
      chk("div1_cyc1_high", int'(clk_out), 5'b11111);
      @(negedge uclk);
      chk("div1_cyc2_low",  int'(clk_out), 5'b00000);

      wait_cyc(4);
      drive(0, 8'd1, 1'b0);   // accept 5, stops at 7
      drive(3, 8'd1, 1'b0);   // accept 6, stops at 7
      drive(4, 8'd1, 1'b0);   // accept 7, stops at 9
      drive(2, 8'd3, 1'b1);   // accept 8, rises 9 with div 3
      drive(1, 8'd2, 1'b1);   // accept 9, rises 11 with div 2

      // ch2 div 3 -> 5 while high: 15..17 high, 18..20 low, then 21..25 high.
      wait_cyc(15);
      drive(2, 8'd5, 1'b1);
      push(2, 21, 10, T_END - 1);
      chk("t2_busy_after_accept", int'(busy), 1);
      wait_cyc(17); chk("t2_ch2_old_high_end", int'(clk_out[2]), 1);
      wait_cyc(18); chk("t2_ch2_old_low",      int'(clk_out[2]), 0);
      wait_cyc(20); chk("t2_ch2_low_end",      int'(clk_out[2]), 0);
                    chk("t2_busy_before_apply", int'(busy), 1);
      wait_cyc(21); chk("t2_ch2_new_rise",     int'(clk_out[2]), 1);
                    chk("t2_busy_after_apply", int'(busy), 0);
      wait_cyc(25); chk("t2_ch2_new_high_end", int'(clk_out[2]), 1);
      wait_cyc(26); chk("t2_ch2_new_fall",     int'(clk_out[2]), 0);

      // ch1 disable while high: the 27..28 high phase completes, then off.
      wait_cyc(27);
      drive(1, 8'd2, 1'b0);
      chk("t3_ch1_high_kept", int'(clk_out[1]), 1);
      wait_cyc(29); chk("t3_ch1_fall", int'(clk_out[1]), 0);
      wait_cyc(31); chk("t3_ch1_off",  int'(clk_out[1]), 0);
      wait_cyc(33); chk("t3_ch1_off2", int'(clk_out[1]), 0);

      // Re-enable at div 2: accept 35, apply 36, rise 38.
      wait_cyc(34);
      drive(1, 8'd2, 1'b1);
      push(1, 38, 4, T_END - 1);
      chk("t3_busy_disabled_accept", int'(busy), 1);
      wait_cyc(36); chk("t3_busy_disabled_apply", int'(busy), 0);
      wait_cyc(37); chk("t3_ch1_still_low", int'(clk_out[1]), 0);
      wait_cyc(38); chk("t3_ch1_rise",      int'(clk_out[1]), 1);

      // Second request to pending ch2 is held off; switching to ch3 goes in.
      wait_cyc(42);
      drive(2, 8'd5, 1'b1);                 // pending until 51, same ratio
      cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd2; cfg_en = 1'b1;
      #1 chk("t4_ready_blocked", int'(cfg_ready), 0);
      @(negedge uclk);
      chk("t4_ready_still_blocked", int'(cfg_ready), 0);
      chk("t4_busy", int'(busy), 1);
      cfg_ch = 3'd3; cfg_div = 8'd0; cfg_en = 1'b1;   // div 0 acts as 1
      #1 chk("t4_ready_other_ch", int'(cfg_ready), 1);
      push(3, 47, 2, T_END - 1);
      @(negedge uclk);
      cfg_valid = 1'b0;

      // Unmapped channel numbers are accepted and have no effect.
      wait_cyc(55);
      cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 8'd9; cfg_en = 1'b0;
      #1 chk("t5_ready_ch5", int'(cfg_ready), 1);
      @(negedge uclk);
      cfg_ch = 3'd7;
      #1 chk("t5_ready_ch7", int'(cfg_ready), 1);
      @(negedge uclk);
      cfg_valid = 1'b0;
      chk("t5_busy_idle", int'(busy), 0);

      // Leave a config pending, then reset mid-operation.
      wait_cyc(63);
      drive(2, 8'd9, 1'b0);
      chk("t6_busy_pending", int'(busy), 1);
      mon_on = 1'b0;
      for (int c = 0; c < NC; c++) chk($sformatf("drain_ch%0d", c), exp_q[c].size(), 0);
      rst = 1'b1;
      @(negedge uclk);
      chk("t6_rst_clk_out",  int'(clk_out), 0);
      chk("t6_rst_clk_tick", int'(clk_tick), 0);
      chk("t6_rst_busy",     int'(busy), 0);
      chk("t6_rst_ready",    int'(cfg_ready), 1);
      rst = 1'b0;
      @(negedge uclk);
      chk("t6_post_rst_rise", int'(clk_out), 5'b11111);
      chk("t6_post_rst_tick", int'(clk_tick), 5'b11111);

`ifdef IXC_UCLK_GEN_SYNC_START_EN
      drive(0, 8'd2, 1'b1);
      drive(1, 8'd3, 1'b1);
      wait_cyc(20);
      chk("sync_busy_idle", int'(busy), 0);
      sync_start = 1'b1;                    // sampled at edge 21
      @(negedge uclk);
      sync_start = 1'b0;
      wait_cyc(22); chk("sync_low_22", int'(clk_out[1:0]), 0);
      wait_cyc(23); chk("sync_ch0_tick_23", int'(clk_tick[1:0]), 2'b01);
      wait_cyc(24); chk("sync_ch1_tick_24", int'(clk_tick[1:0]), 2'b10);
      wait_cyc(27); chk("sync_ch0_tick_27", int'(clk_tick[0]), 1);
      wait_cyc(30); chk("sync_ch1_tick_30", int'(clk_tick[1]), 1);
      wait_cyc(35); chk("sync_ch0_tick_35", int'(clk_tick[0]), 1);
      wait_cyc(36); chk("sync_ch1_tick_36", int'(clk_tick[1]), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
